bpu_bimodal: RTL and testbench

- Parametrised dynamic branch predictor replacing the fetch stage's fixed static prediction.
- Sits beside pc_reg/ifu:
  - combinational lookup on the current fetch PC drives prdt_taken/prdt_target into pc_reg and if_id;
  - EX-stage resolution of each control-flow instruction trains a tagged BTB with per-entry saturating counters.
- Also counts lookups-that-resolved and mispredicts for performance analysis.

---
 rtl/bpu_bimodal_pkg.sv | 12 +
 rtl/bpu_bimodal_if.sv | 30 +++
 rtl/bpu_bimodal_sat_ctr.sv | 23 ++
 rtl/bpu_bimodal.sv | 93 +++++++++
 tb/tb_bpu_bimodal.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bpu_bimodal_pkg.sv
// Shared definitions for the bimodal branch predictor: address width and
// the direction encoding used by fetch and EX.
package bpu_bimodal_pkg;

    localparam int unsigned INST_ADDR_W = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } dir_e;

endpackage

// File: rtl/bpu_bimodal_if.sv
// Predictor bus: fetch-side lookup, EX-side training and statistics.
// The pipeline is the master; the predictor is the slave.
interface bpu_bimodal_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STAT_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              prdt_taken_o;
    logic [ADDR_W-1:0] prdt_target_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_mispred_i;
    logic              clear_i;
    logic [STAT_W-1:0] stat_branches_o;
    logic [STAT_W-1:0] stat_mispred_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispred_i, clear_i,
        input  prdt_taken_o, prdt_target_o, stat_branches_o, stat_mispred_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispred_i, clear_i,
        output prdt_taken_o, prdt_target_o, stat_branches_o, stat_mispred_o
    );
endinterface

// File: rtl/bpu_bimodal_sat_ctr.sv
// Next-value logic for a W-bit saturating counter: load has priority,
// then increment (capped at all-ones), then decrement (floored at zero).
module bpu_bimodal_sat_ctr #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (inc && (cur != '1)) begin
            nxt = cur + W'(1);
        end else if (dec && (cur != '0)) begin
            nxt = cur - W'(1);
        end
    end
endmodule

// File: rtl/bpu_bimodal.sv
// Bimodal branch predictor: tagged BTB with per-entry saturating counters,
// zero-latency lookup, registered training and saturating statistics.
module bpu_bimodal
    import bpu_bimodal_pkg::*;
#(
    parameter int unsigned ADDR_W  = INST_ADDR_W,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned STAT_W  = 32
) (
    input logic           clk,
    input logic           rst,
    bpu_bimodal_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] WEAK_NT = WEAK_T - CTR_W'(1);

    logic              valid   [ENTRIES];
    logic [TAG_W-1:0]  tags    [ENTRIES];
    logic [ADDR_W-1:0] targets [ENTRIES];
    logic [CTR_W-1:0]  ctrs    [ENTRIES];

    logic [STAT_W-1:0] stat_br;
    logic [STAT_W-1:0] stat_mp;

    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic              look_hit;
    logic              look_taken;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_taken;
    logic [CTR_W-1:0]  ctr_nxt;

    assign look_idx   = bus.pc_i[IDX_W+1:2];
    assign look_tag   = bus.pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign look_hit   = valid[look_idx] && (tags[look_idx] == look_tag);
    assign look_taken = look_hit && ctrs[look_idx][CTR_W-1];

    assign bus.prdt_taken_o    = look_taken;
    assign bus.prdt_target_o   = look_taken ? targets[look_idx] : '0;
    assign bus.stat_branches_o = stat_br;
    assign bus.stat_mispred_o  = stat_mp;

    assign upd_idx   = bus.upd_pc_i[IDX_W+1:2];
    assign upd_tag   = bus.upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_hit   = valid[upd_idx] && (tags[upd_idx] == upd_tag);
    assign upd_taken = (dir_e'(bus.upd_taken_i) == TAKEN);

    bpu_bimodal_sat_ctr #(.W(CTR_W)) u_sat_ctr (
        .cur      (ctrs[upd_idx]),
        .inc      (upd_hit && upd_taken),
        .dec      (upd_hit && !upd_taken),
        .load     (!upd_hit && upd_taken),
        .load_val (WEAK_T),
        .nxt      (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= WEAK_NT;
            end
            stat_br <= '0;
            stat_mp <= '0;
        end else begin
            // Clear beats a concurrent allocation; statistics still count it.
            if (bus.clear_i) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    valid[i] <= 1'b0;
                end
            end else if (bus.upd_valid_i && (upd_hit || upd_taken)) begin
                ctrs[upd_idx] <= ctr_nxt;
                if (upd_taken) begin
                    valid[upd_idx]   <= 1'b1;
                    tags[upd_idx]    <= upd_tag;
                    targets[upd_idx] <= bus.upd_target_i;
                end
            end
            if (bus.upd_valid_i) begin
                if (stat_br != '1) stat_br <= stat_br + STAT_W'(1);
                if (bus.upd_mispred_i && (stat_mp != '1)) stat_mp <= stat_mp + STAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bpu_bimodal.sv
// Directed and randomized checks of bpu_bimodal against a table-level model.
module tb_bpu_bimodal;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned STAT_W  = 4;
    localparam int          CTR_MAX = 3;
    localparam int          STAT_MAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bpu_bimodal_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bus ();

    bpu_bimodal #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES),
        .CTR_W  (2),
        .TAG_W  (8),
        .STAT_W (STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br, m_mp;

    logic              o_taken;
    logic [ADDR_W-1:0] o_tgt;
    logic [STAT_W-1:0] o_br, o_mp;

    function automatic int unsigned idx_of(int unsigned pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(int unsigned pc);
        return (pc / (4 * ENTRIES)) % 256;
    endfunction

    task automatic chk(string name, logic [ADDR_W-1:0] obs, logic [ADDR_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_edge(bit r, bit clr, bit uv, int unsigned upc, bit ut,
                              int unsigned utgt, bit um);
        int unsigned i;
        if (r) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
            end
            m_br = 0; m_mp = 0;
            return;
        end
        if (clr) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (uv) begin
            i = idx_of(upc);
            if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
                if (ut) begin
                    if (m_ctr[i] < CTR_MAX) m_ctr[i]++;
                    m_tgt[i] = utgt;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (ut) begin
                m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt; m_ctr[i] = 2;
            end
        end
        if (uv) begin
            if (m_br < STAT_MAX) m_br++;
            if (um && m_mp < STAT_MAX) m_mp++;
        end
    endtask

    // One clock: drive, check the pre-edge lookup and stats, then advance.
    task automatic cycle(bit r, int unsigned pc, bit uv, int unsigned upc, bit ut,
                         int unsigned utgt, bit um, bit clr);
        int unsigned i;
        bit exp_taken;
        rst = r;
        bus.pc_i = pc;
        bus.upd_valid_i = uv;
        bus.upd_pc_i = upc;
        bus.upd_taken_i = ut;
        bus.upd_target_i = utgt;
        bus.upd_mispred_i = um;
        bus.clear_i = clr;
        #4;
        i = idx_of(pc);
        exp_taken = m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
        o_taken = bus.prdt_taken_o;
        o_tgt   = bus.prdt_target_o;
        o_br    = bus.stat_branches_o;
        o_mp    = bus.stat_mispred_o;
        chk("model_taken", ADDR_W'(o_taken), ADDR_W'(exp_taken));
        chk("model_target", o_tgt, exp_taken ? m_tgt[i] : 0);
        chk("model_stat_br", ADDR_W'(o_br), m_br);
        chk("model_stat_mp", ADDR_W'(o_mp), m_mp);
        @(posedge clk);
        #1;
        model_edge(r, clr, uv, upc, ut, utgt, um);
    endtask

    task automatic look(int unsigned pc);
        cycle(0, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(int unsigned upc, bit ut, int unsigned utgt);
        cycle(0, 'h4, 1, upc, ut, utgt, 0, 0);
    endtask

    initial begin
        int unsigned pc, upc;
        logic [STAT_W-1:0] br_before;
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
        end
        m_br = 0; m_mp = 0;
        rst = 1'b1;
        bus.pc_i = '0; bus.upd_valid_i = 0; bus.upd_pc_i = '0; bus.upd_taken_i = 0;
        bus.upd_target_i = '0; bus.upd_mispred_i = 0; bus.clear_i = 0;
        @(posedge clk);
        #1;

        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        look('h100);
        chk("reset_taken", ADDR_W'(o_taken), 0);
        chk("reset_target", o_tgt, 0);
        chk("reset_stat_br", ADDR_W'(o_br), 0);
        chk("reset_stat_mp", ADDR_W'(o_mp), 0);

        // Allocation, then one not-taken back to weakly not-taken
        upd('h100, 1, 'h80);
        look('h100);
        chk("alloc_taken", ADDR_W'(o_taken), 1);
        chk("alloc_target", o_tgt, 'h80);
        upd('h100, 0, 0);
        look('h100);
        chk("alloc_nt_taken", ADDR_W'(o_taken), 0);

        // Alias: same index, different tag
        upd('h100, 1, 'h80);
        look('h200);
        chk("alias_miss", ADDR_W'(o_taken), 0);
        upd('h200, 1, 'h40);
        look('h100);
        chk("evicted_miss", ADDR_W'(o_taken), 0);

        // Saturation
        for (int k = 0; k < 4; k++) upd('h200, 1, 'h40);
        upd('h200, 0, 0);
        look('h200);
        chk("sat_one_nt", ADDR_W'(o_taken), 1);
        chk("sat_target", o_tgt, 'h40);
        upd('h200, 0, 0);
        look('h200);
        chk("sat_two_nt", ADDR_W'(o_taken), 0);

        // Same-cycle lookup and update
        cycle(0, 'h300, 1, 'h300, 1, 'h124, 0, 0);
        chk("sim_same_cycle", ADDR_W'(o_taken), 0);
        look('h300);
        chk("sim_next_cycle", ADDR_W'(o_taken), 1);
        chk("sim_next_target", o_tgt, 'h124);

        // Clear together with an update
        br_before = o_br;
        cycle(0, 'h4, 1, 'h400, 1, 'h88, 1, 1);
        look('h400);
        chk("clear_no_alloc", ADDR_W'(o_taken), 0);
        chk("clear_stat_br", ADDR_W'(o_br), ADDR_W'(br_before) + 1);
        look('h300);
        chk("clear_invalid", ADDR_W'(o_taken), 0);

        // Statistics saturation
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle(0, 'h8, 1, 'h500 + 4 * k, k % 2, 'h10, 1, 0);
        look('h8);
        chk("stat_br_sat", ADDR_W'(o_br), 15);
        chk("stat_mp_sat", ADDR_W'(o_mp), 15);

        // Mid-stream reset discards the in-flight update
        upd('h600, 1, 'h60);
        cycle(1, 'h600, 1, 'h600, 1, 'h60, 1, 0);
        look('h600);
        chk("midrst_taken", ADDR_W'(o_taken), 0);
        chk("midrst_stat", ADDR_W'(o_br), 0);

        // Randomized traffic over a small aliasing address set
        for (int k = 0; k < 600; k++) begin
            pc  = $urandom_range(0, 7) * 4 + $urandom_range(0, 2) * 256;
            upc = $urandom_range(0, 7) * 4 + $urandom_range(0, 2) * 256;
            if (k % 150 == 0) begin
                cycle(1, pc, 1, upc, 1, 'h40, 1, 0);
            end else begin
                cycle(0, pc, ($urandom_range(0, 3) != 0), upc, $urandom_range(0, 1),
                      $urandom_range(0, 255) * 4, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 49) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
